// File: rtl/inst_rom_loader_pkg.sv
// rtl/inst_rom_loader_pkg.sv - shared NOP constant and loader FSM state type
package inst_rom_loader_pkg;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/inst_rom_loader_if.sv
// rtl/inst_rom_loader_if.sv - byte-wide download stream with valid/ready handshake
interface inst_rom_loader_if;

  logic       byte_valid_i;
  logic [7:0] byte_data_i;
  logic       byte_ready_o;

  modport master (output byte_valid_i, output byte_data_i, input byte_ready_o);
  modport slave  (input byte_valid_i, input byte_data_i, output byte_ready_o);

endinterface

// File: rtl/inst_rom_loader_byte_packer.sv
// rtl/inst_rom_loader_byte_packer.sv - little-endian byte-to-word assembler with word-valid pulse
module inst_rom_loader_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0]  r_lane;
  logic [23:0] r_shift;

  // Lane counter and the three earlier bytes; new bytes enter at the top so the first ends in [7:0]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane  <= '0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_lane  <= '0;
      r_shift <= '0;
    end else if (i_accept) begin
      r_lane  <= r_lane + 2'd1;
      r_shift <= {i_byte, r_shift[23:8]};
    end
  end

  // The fourth byte completes the word in the same cycle it is accepted
  assign o_word       = {i_byte, r_shift};
  assign o_word_valid = i_accept && (r_lane == 2'd3);

endmodule

// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - run-time loaded instruction memory; ROM_LOAD_CHECKSUM_EN adds a checksum trailer
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       inst_addr_i,
  output logic [31:0]       inst_o,
  input  logic              load_start_i,
  input  logic [ADDR_W:0]   load_len_i,
  inst_rom_loader_if.slave  byte_if,
  output logic              core_rst_n_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic              load_err_o
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);
`ifdef ROM_LOAD_CHECKSUM_EN
  localparam state_t LP_AFTER_PAYLOAD = ST_CHECK;
`else
  localparam state_t LP_AFTER_PAYLOAD = ST_DONE;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ADDR_W:0]  r_len;
  logic [ADDR_W:0]  r_idx;
  logic             r_err;
  logic             r_core_rst_n;
  logic [31:0]      r_mem [DEPTH];
`ifdef ROM_LOAD_CHECKSUM_EN
  logic [31:0]      r_sum;
`endif

  logic             w_ready;
  logic             w_accept;
  logic             w_start;
  logic             w_too_long;
  logic [31:0]      w_word;
  logic             w_word_valid;
  logic             w_last_word;
  logic [ADDR_W-1:0] w_fetch_idx;
  logic             w_fetch_hi_zero;
  logic             w_unused_addr_lsb;

  assign w_ready       = (r_state == ST_LOAD) || (r_state == ST_CHECK);
  assign w_accept      = byte_if.byte_valid_i && w_ready;
  assign w_start       = (r_state == ST_IDLE) && load_start_i;
  assign w_too_long    = load_len_i > LP_DEPTH;
  assign w_last_word   = (r_state == ST_LOAD) && w_word_valid && ((r_idx + 1'b1) == r_len);

  inst_rom_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_start),
    .i_accept     (w_accept),
    .i_byte       (byte_if.byte_data_i),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state selection; an oversize length leaves the FSM in IDLE with the error flag set
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (load_start_i && !w_too_long)
          w_state_nxt = (load_len_i == '0) ? LP_AFTER_PAYLOAD : ST_LOAD;
      end
      ST_LOAD: begin
        if (w_last_word) w_state_nxt = LP_AFTER_PAYLOAD;
      end
`ifdef ROM_LOAD_CHECKSUM_EN
      ST_CHECK: begin
        if (w_word_valid) w_state_nxt = (w_word == r_sum) ? ST_DONE : ST_IDLE;
      end
`endif
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Load bookkeeping: length, word index, error flag, core reset release and running checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len        <= '0;
      r_idx        <= '0;
      r_err        <= 1'b0;
      r_core_rst_n <= 1'b0;
`ifdef ROM_LOAD_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      if (w_start) begin
        r_len        <= load_len_i;
        r_idx        <= '0;
        r_err        <= w_too_long;
        r_core_rst_n <= 1'b0;
`ifdef ROM_LOAD_CHECKSUM_EN
        r_sum        <= '0;
`endif
      end else if ((r_state == ST_LOAD) && w_word_valid) begin
        r_idx <= r_idx + 1'b1;
`ifdef ROM_LOAD_CHECKSUM_EN
        r_sum <= r_sum + w_word;
`endif
      end
`ifdef ROM_LOAD_CHECKSUM_EN
      if ((r_state == ST_CHECK) && w_word_valid && (w_word != r_sum))
        r_err <= 1'b1;
`endif
      // Release the core on entry to DONE so it rises in the same cycle as the done pulse
      if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE))
        r_core_rst_n <= 1'b1;
    end
  end

  // Instruction memory write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if ((r_state == ST_LOAD) && w_word_valid)
      r_mem[r_idx[ADDR_W-1:0]] <= w_word;
  end

  assign w_fetch_idx       = inst_addr_i[ADDR_W+1:2];
  assign w_fetch_hi_zero   = (inst_addr_i[31:ADDR_W+2] == '0);
  assign w_unused_addr_lsb = ^inst_addr_i[1:0];

  // Fetch returns NOP while loading, outside the memory, or when no valid image is held
  assign inst_o = (load_busy_o || !w_fetch_hi_zero || !r_core_rst_n) ? NOP : r_mem[w_fetch_idx];

  assign byte_if.byte_ready_o = w_ready;
  assign core_rst_n_o         = r_core_rst_n;
  assign load_busy_o          = (r_state != ST_IDLE);
  assign load_done_o          = (r_state == ST_DONE);
  assign load_err_o           = r_err;

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb/tb_inst_rom_loader.sv - scoreboard bench for inst_rom_loader with a word-level reference model
module tb_inst_rom_loader;

  localparam int DEPTH  = 4096;
  localparam int ADDR_W = 12;
  localparam logic [31:0] NOP_W = 32'h00000013;
`ifdef ROM_LOAD_CHECKSUM_EN
  localparam bit HAS_SUM = 1'b1;
`else
  localparam bit HAS_SUM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       inst_addr = '0;
  logic [31:0]       inst;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              core_rst_n;
  logic              load_busy;
  logic              load_done;
  logic              load_err;

  inst_rom_loader_if bif ();

  inst_rom_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_addr_i  (inst_addr),
    .inst_o       (inst),
    .load_start_i (load_start),
    .load_len_i   (load_len),
    .byte_if      (bif),
    .core_rst_n_o (core_rst_n),
    .load_busy_o  (load_busy),
    .load_done_o  (load_done),
    .load_err_o   (load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_edge = 0;
  int last_done_cyc = -1;

  logic [2:0]  ev_q[$];
  logic [31:0] fetch_q[$];
  logic        fetch_req = 1'b0;
  logic        err_q = 1'b0;

  logic [31:0] ref_mem [int];
  bit          img_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_fetch(input logic [31:0] a);
    if (!img_valid || a[31:ADDR_W+2] != '0) return NOP_W;
    if (!ref_mem.exists(int'(a[ADDR_W+1:2]))) return NOP_W;
    return ref_mem[int'(a[ADDR_W+1:2])];
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: done pulses and rising errors pop the event queue; flagged fetches pop the fetch queue
  always @(negedge clk) begin
    logic [2:0] got;
    if (!rst_n) begin
      err_q = 1'b0;
    end else begin
      if (load_done || (load_err && !err_q)) begin
        got = {load_done, load_err, core_rst_n};
        if (load_done) last_done_cyc = cyc;
        if (ev_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_event: got %b expected none", got);
        end else begin
          check("load_event", 32'(got), 32'(ev_q.pop_front()));
        end
      end
      if (fetch_req) begin
        if (fetch_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL fetch_queue: got empty queue expected entry");
        end else begin
          check("fetch", inst, fetch_q.pop_front());
        end
      end
      err_q = load_err;
    end
  end

  task automatic fetch(input logic [31:0] a);
    @(posedge clk); #1;
    inst_addr = a;
    fetch_q.push_back(ref_fetch(a));
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  task automatic do_start(input int len);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = (ADDR_W + 1)'(len);
    start_edge = cyc + 1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    if (gap > 0) begin
      bif.byte_valid_i = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bif.byte_valid_i = 1'b1;
    bif.byte_data_i  = b;
    while (!bif.byte_ready_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL byte_ready_timeout: got ready 0 expected 1");
    end
    @(negedge clk);
  endtask

  function automatic int pick_gap(input int mode, input bit first);
    if (mode == 1) return first ? 0 : 1;
    if (mode == 2) return $urandom_range(0, 2);
    return 0;
  endfunction

  task automatic send_word(input logic [31:0] w, input int mode, inout int gaps, inout bit first);
    int g;
    for (int b = 0; b < 4; b++) begin
      g = pick_gap(mode, first);
      gaps += g;
      first = 1'b0;
      send_byte(w[8*b +: 8], g);
    end
  endtask

  task automatic run_load(input int len, input logic [31:0] words[$], input int gap_mode,
                          input bit bad_sum, input bit poke);
    logic [31:0] sum = '0;
    logic [31:0] w;
    bit ok;
    bit first = 1'b1;
    int gaps = 0;
    int nbytes;
    int t = 0;
    if (len > DEPTH) begin
      ev_q.push_back(3'b010);
      img_valid = 1'b0;
      do_start(len);
      check("busy_bad_len", 32'(load_busy), 32'(0));
      check("err_bad_len", 32'(load_err), 32'(1));
      check("core_rst_bad_len", 32'(core_rst_n), 32'(0));
      repeat (3) @(negedge clk);
      check("busy_stays_low", 32'(load_busy), 32'(0));
      check("ready_stays_low", 32'(bif.byte_ready_o), 32'(0));
      @(posedge clk); #1;
      check("events_drained", 32'(ev_q.size()), 32'(0));
      return;
    end
    foreach (words[i]) sum += words[i];
    ok = HAS_SUM ? !bad_sum : 1'b1;
    nbytes = 4 * len + (HAS_SUM ? 4 : 0);
    ev_q.push_back(ok ? 3'b101 : 3'b010);
    img_valid = 1'b0;
    do_start(len);
    check("busy_after_start", 32'(load_busy), 32'(1));
    check("ready_after_start", 32'(bif.byte_ready_o), 32'((len > 0) || HAS_SUM));
    check("err_cleared_by_start", 32'(load_err), 32'(0));
    if (poke && len > 0) begin
      load_start = 1'b1;
      load_len   = (ADDR_W + 1)'(DEPTH + 1);
      bif.byte_valid_i = 1'b0;
      @(negedge clk);
      load_start = 1'b0;
      gaps += 1;
      first = 1'b0;
    end
    for (int i = 0; i < len; i++) begin
      send_word(words[i], gap_mode, gaps, first);
      ref_mem[i] = words[i];
    end
    if (HAS_SUM) begin
      w = bad_sum ? sum + 32'h0000_0100 : sum;
      send_word(w, gap_mode, gaps, first);
    end
    bif.byte_valid_i = 1'b0;
    while (load_busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL busy_timeout: got busy 1 expected 0");
    end
    img_valid = ok;
    @(posedge clk); #1;
    check("events_drained", 32'(ev_q.size()), 32'(0));
    check("core_rst_after_load", 32'(core_rst_n), 32'(ok));
    check("err_after_load", 32'(load_err), 32'(!ok));
    if (ok) check("done_latency", 32'(last_done_cyc - start_edge), 32'(nbytes + gaps));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] wq[$];
    logic [31:0] first_try[$];
    int len;
    bif.byte_valid_i = 1'b0;
    bif.byte_data_i  = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_core_rst", 32'(core_rst_n), 32'(0));
    check("reset_ready", 32'(bif.byte_ready_o), 32'(0));
    check("reset_busy", 32'(load_busy), 32'(0));
    check("reset_done", 32'(load_done), 32'(0));
    check("reset_err", 32'(load_err), 32'(0));
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);
    fetch(32'h0001_0000);

    wq = {32'h00100513, 32'h00200593};
    run_load(2, wq, 0, 1'b0, 1'b0);
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);
    fetch(32'h0000_0007);
    fetch(32'h0001_0004);

    run_load(2, wq, 1, 1'b0, 1'b0);
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);

    wq.delete();
    run_load(DEPTH + 1, wq, 0, 1'b0, 1'b0);
    fetch(32'h0000_0000);

    run_load(0, wq, 0, 1'b0, 1'b0);
    fetch(32'h0000_0004);

    first_try = {$urandom, $urandom, $urandom};
    img_valid = 1'b0;
    do_start(3);
    for (int i = 0; i < 5; i++) begin
      wq = {first_try[i / 4]};
      send_byte(wq[0][8*(i % 4) +: 8], 0);
      if (i == 3) ref_mem[0] = first_try[0];
    end
    bif.byte_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midload_reset_core", 32'(core_rst_n), 32'(0));
    check("midload_reset_busy", 32'(load_busy), 32'(0));
    check("midload_reset_ready", 32'(bif.byte_ready_o), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    wq = {$urandom};
    run_load(1, wq, 0, 1'b0, 1'b0);
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);

    if (HAS_SUM) begin
      wq = {$urandom, $urandom};
      run_load(2, wq, 0, 1'b1, 1'b0);
      fetch(32'h0000_0000);
      run_load(2, wq, 2, 1'b0, 1'b0);
      fetch(32'h0000_0000);
      fetch(32'h0000_0004);
    end

    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, 6);
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back($urandom);
      run_load(len, wq, $urandom_range(0, 2), HAS_SUM && ($urandom_range(0, 3) == 0),
               $urandom_range(0, 1) == 1);
      for (int i = 0; i < len; i++) fetch(32'(i * 4 + $urandom_range(0, 3)));
      fetch($urandom | 32'h0001_0000);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
